// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler sharing one signed fixed-point multiplier
// among N_REQ requesters. Two pipeline stages: S1 holds the granted operands,
// S2 holds the scaled product. Backpressure from res_ready propagates into
// the grant logic, so nothing is dropped.
module mult_sched #(
    parameter int N_REQ   = 4,
    parameter int A_BITS  = 18,
    parameter int A_POINT = 14,
    parameter int B_BITS  = 18,
    parameter int B_POINT = 14,
    parameter int C_BITS  = 18,
    parameter int C_POINT = 14,
    localparam int ID_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*A_BITS-1:0]    req_a,
    input  logic [N_REQ*B_BITS-1:0]    req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [C_BITS-1:0]   res_c,
    output logic [ID_BITS-1:0]         res_id
);

    localparam int PW     = A_BITS + B_BITS;
    localparam int RSHIFT = A_POINT + B_POINT - C_POINT;
    localparam int LSH    = (RSHIFT < 0) ? -RSHIFT : 0;
    localparam int RSH    = (RSHIFT > 0) ? RSHIFT : 0;
    // Headroom for a left shift plus sign bits when C_BITS exceeds the product
    localparam int XW     = PW + LSH + C_BITS;

    logic                       s1_valid;
    logic signed [A_BITS-1:0]   s1_a;
    logic signed [B_BITS-1:0]   s1_b;
    logic [ID_BITS-1:0]         s1_id;
    logic [ID_BITS-1:0]         ptr;

    logic                       adv1;
    logic                       adv2;
    logic                       gnt_any;
    logic [ID_BITS-1:0]         gnt_id;
    logic signed [A_BITS-1:0]   gnt_a;
    logic signed [B_BITS-1:0]   gnt_b;
    logic [N_REQ-1:0]           grant;
    logic [ID_BITS-1:0]         ptr_next;

    logic signed [PW-1:0]       prod;
    logic signed [XW-1:0]       prod_x;
    logic signed [C_BITS-1:0]   c_next;

    // Stage advance conditions: a stage may move when the one ahead frees up
    always_comb begin
        adv2 = !res_valid || res_ready;
        adv1 = !s1_valid || adv2;
    end

    // Round-robin search from ptr, wrapping; grant suppressed on stall or reset
    always_comb begin
        int idx;
        idx      = 0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        gnt_a    = '0;
        gnt_b    = '0;
        grant    = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            idx = (int'(ptr) + int'(j)) % N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_BITS'(idx);
                gnt_a   = req_a[idx*A_BITS +: A_BITS];
                gnt_b   = req_b[idx*B_BITS +: B_BITS];
            end
        end
        if (!adv1 || !rst_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            grant[gnt_id] = 1'b1;
        end
        ptr_next  = ID_BITS'((int'(gnt_id) + 1) % N_REQ);
        req_ready = grant;
    end

    // Full-width signed product, then scale to the result point and wrap
    always_comb begin
        prod   = PW'(s1_a) * PW'(s1_b);
        prod_x = XW'(prod);
        c_next = C_BITS'((prod_x <<< LSH) >>> RSH);
    end

    // S1 and priority pointer: load on grant, clear to empty when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            ptr      <= '0;
        end else if (adv1) begin
            s1_valid <= gnt_any;
            if (gnt_any) begin
                s1_a  <= gnt_a;
                s1_b  <= gnt_b;
                s1_id <= gnt_id;
                ptr   <= ptr_next;
            end
        end
    end

    // S2 result register: holds contents while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_c     <= '0;
            res_id    <= '0;
        end else if (adv2) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_c  <= c_next;
                res_id <= s1_id;
            end
        end
    end

endmodule
